// File: rtl/vec_inc_engine.sv
// vec_inc_engine: vector increment personality. On CAEP 0 it reads COUNT
// 64-bit words starting at BASE, adds INC to each one and writes the result
// back in place. Element i is handled by memory channel i % NUM_MC. Each
// channel has its own issue logic, response FIFO and credit counter.
//
// Optional feature macro: WR_FLUSH_EN. When it is defined, a FLUSH state
// follows RUN. A flush request is pulsed on every channel, and the engine
// returns to IDLE only after every channel has reported flush complete.
// The default build (macro undefined) has no FLUSH state and ties
// mc_req_flush_o to 0.
module vec_inc_engine #(
  parameter int NUM_MC     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  aeg_write_i,
  input  logic                  aeg_read_i,
  input  logic [17:0]           aeg_index_i,
  input  logic [63:0]           aeg_data_i,
  output logic [17:0]           aeg_count_o,
  input  logic                  instruction_valid_i,
  input  logic [4:0]            instruction_caep_i,
  output logic [63:0]           return_data_o,
  output logic                  return_data_valid_o,
  output logic [15:0]           exception_o,
  output logic                  idle_o,
  output logic                  stall_o,
  output logic [NUM_MC-1:0]     mc_req_ld_o,
  output logic [NUM_MC-1:0]     mc_req_st_o,
  output logic [2*NUM_MC-1:0]   mc_req_size_o,
  output logic [48*NUM_MC-1:0]  mc_req_vadr_o,
  output logic [64*NUM_MC-1:0]  mc_req_wrd_rdctl_o,
  input  logic [NUM_MC-1:0]     mc_rd_rq_stall_i,
  input  logic [NUM_MC-1:0]     mc_wr_rq_stall_i,
  input  logic [NUM_MC-1:0]     mc_rsp_push_i,
  input  logic [64*NUM_MC-1:0]  mc_rsp_data_i,
  input  logic [32*NUM_MC-1:0]  mc_rsp_rdctl_i,
  output logic [NUM_MC-1:0]     mc_rsp_stall_o,
  output logic [NUM_MC-1:0]     mc_req_flush_o,
  input  logic [NUM_MC-1:0]     mc_rsp_flush_cmplt_i
);

  // state | meaning
  // IDLE  | waiting for dispatch; AEGs 0-2 writable
  // RUN   | loads/stores in flight until DONE == COUNT
  // FLUSH | (WR_FLUSH_EN) waiting for flush complete on all channels
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
`ifdef WR_FLUSH_EN
  localparam logic [1:0] S_FLUSH = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [47:0]      base_q;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      inc_q;
  logic [CNT_W-1:0] done_q;
  logic [63:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             exc_q;
  logic             start;
  logic             run;
  logic [NUM_MC-1:0] st_vec;
  logic [CNT_W-1:0] st_cnt;
  logic             flush_done;

  assign start = (state_q == S_IDLE) && instruction_valid_i && (instruction_caep_i == 5'd0);
  assign run   = (state_q == S_RUN);

  assign aeg_count_o         = 18'd4;
  assign return_data_o       = rd_data_q;
  assign return_data_valid_o = rd_valid_q;
  assign exception_o         = {15'd0, exc_q};
  assign idle_o              = (state_q == S_IDLE);
  assign stall_o             = (state_q != S_IDLE) || instruction_valid_i;
  assign mc_req_size_o       = {NUM_MC{2'd3}};

`ifdef WR_FLUSH_EN
  logic              flush_q;
  logic [NUM_MC-1:0] seen_q;

  assign flush_done     = &(seen_q | mc_rsp_flush_cmplt_i);
  assign mc_req_flush_o = {NUM_MC{flush_q}};

  // One-cycle flush pulse on FLUSH entry; completions are sticky per channel.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      flush_q <= 1'b0;
      seen_q  <= '0;
    end else begin
      flush_q <= (state_q == S_RUN) && (state_d == S_FLUSH);
      if ((state_q == S_RUN) && (state_d == S_FLUSH))
        seen_q <= '0;
      else if (state_q == S_FLUSH)
        seen_q <= seen_q | mc_rsp_flush_cmplt_i;
    end
  end
`else
  logic unused_flush_cmplt;
  assign unused_flush_cmplt = |mc_rsp_flush_cmplt_i;
  assign flush_done         = 1'b0;
  assign mc_req_flush_o     = '0;
`endif

  // Next-state logic for the dispatch FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (done_q == count_q) begin
`ifdef WR_FLUSH_EN
          state_d = S_FLUSH;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef WR_FLUSH_EN
      S_FLUSH: if (flush_done) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // AEG file: BASE/COUNT/INC are writable only while idle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      base_q  <= '0;
      count_q <= '0;
      inc_q   <= '0;
    end else if (aeg_write_i && (state_q == S_IDLE)) begin
      case (aeg_index_i)
        18'd0:   base_q  <= aeg_data_i[47:0];
        18'd1:   count_q <= aeg_data_i[CNT_W-1:0];
        18'd2:   inc_q   <= aeg_data_i;
        default: ;
      endcase
    end
  end

  // Number of stores issued across all channels this cycle.
  always_comb begin
    st_cnt = '0;
    for (int i = 0; i < NUM_MC; i++)
      st_cnt = st_cnt + CNT_W'(st_vec[i]);
  end

  // DONE counts completed element stores for the current operation.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)  done_q <= '0;
    else if (start) done_q <= '0;
    else if (run)   done_q <= done_q + st_cnt;
  end

  // AEG read mux; anything past index 3 reads as zero.
  always_comb begin
    rd_data_d = '0;
    case (aeg_index_i)
      18'd0:   rd_data_d = 64'(base_q);
      18'd1:   rd_data_d = 64'(count_q);
      18'd2:   rd_data_d = inc_q;
      18'd3:   rd_data_d = 64'(done_q);
      default: rd_data_d = '0;
    endcase
  end

  // Registered AEG read return and unsupported-CAEP exception pulse.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      rd_valid_q <= aeg_read_i;
      if (aeg_read_i) rd_data_q <= rd_data_d;
      exc_q <= (state_q == S_IDLE) && instruction_valid_i && (instruction_caep_i != 5'd0);
    end
  end

  for (genvar c = 0; c < NUM_MC; c++) begin : g_ch
    logic [CNT_W:0]   idx_q;
    logic [CW-1:0]    credit_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    wp_q, rp_q;
    logic [63:0]      fd_q [FIFO_DEPTH];
    logic [CNT_W-1:0] fc_q [FIFO_DEPTH];
    logic             push, st, ld;
    logic [CNT_W-1:0] head_idx;
    logic [63:0]      head_data;
    logic [47:0]      st_vadr, ld_vadr;

    // Responses arriving while idle belong to an aborted operation; drop them.
    assign push      = mc_rsp_push_i[c] && (state_q != S_IDLE) && (cnt_q != CW'(FIFO_DEPTH));
    assign head_idx  = fc_q[rp_q];
    assign head_data = fd_q[rp_q];
    assign st        = run && (cnt_q != '0) && !mc_wr_rq_stall_i[c];
    // The credit bound covers loads in flight plus FIFO entries, so the FIFO cannot overflow.
    assign ld        = run && !st && (idx_q < {1'b0, count_q})
                       && (credit_q < CW'(FIFO_DEPTH)) && !mc_rd_rq_stall_i[c];
    assign st_vadr   = base_q + (48'(head_idx) << 3);
    assign ld_vadr   = base_q + (48'(idx_q[CNT_W-1:0]) << 3);

    assign st_vec[c]                   = st;
    assign mc_req_st_o[c]              = st;
    assign mc_req_ld_o[c]              = ld;
    assign mc_req_vadr_o[c*48 +: 48]   = st ? st_vadr : (ld ? ld_vadr : 48'd0);
    assign mc_req_wrd_rdctl_o[c*64 +: 64] = st ? (head_data + inc_q)
                                          : (ld ? 64'(idx_q[CNT_W-1:0]) : 64'd0);
    assign mc_rsp_stall_o[c]           = (cnt_q >= CW'(FIFO_DEPTH - 2));

    // Channel element index, credit count and FIFO pointers.
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        idx_q    <= '0;
        credit_q <= '0;
        cnt_q    <= '0;
        wp_q     <= '0;
        rp_q     <= '0;
      end else if (start) begin
        idx_q    <= (CNT_W+1)'(c);
        credit_q <= '0;
        cnt_q    <= '0;
        wp_q     <= '0;
        rp_q     <= '0;
      end else begin
        if (ld)   idx_q <= idx_q + (CNT_W+1)'(NUM_MC);
        if (push) wp_q  <= wp_q + AW'(1);
        if (st)   rp_q  <= rp_q + AW'(1);
        credit_q <= credit_q + CW'(ld) - CW'(st);
        cnt_q    <= cnt_q + CW'(push) - CW'(st);
      end
    end

    // Response FIFO storage: read data plus the returned element index.
    always_ff @(posedge clock_i) begin
      if (push) begin
        fd_q[wp_q] <= mc_rsp_data_i[c*64 +: 64];
        fc_q[wp_q] <= mc_rsp_rdctl_i[c*32 +: CNT_W];
      end
    end
  end

endmodule

// File: tb/tb_vec_inc_engine.sv
module tb_vec_inc_engine;
  localparam int NMC = 2;
  localparam int FD  = 4;
  localparam int CW  = 32;

  logic              clock, reset;
  logic              aeg_write, aeg_read;
  logic [17:0]       aeg_index;
  logic [63:0]       aeg_data;
  logic [17:0]       aeg_count;
  logic              instruction_valid;
  logic [4:0]        caep;
  logic [63:0]       return_data;
  logic              rdv;
  logic [15:0]       exception;
  logic              idle, stall;
  logic [NMC-1:0]    req_ld, req_st;
  logic [2*NMC-1:0]  req_size;
  logic [48*NMC-1:0] req_vadr;
  logic [64*NMC-1:0] req_wrd;
  logic [NMC-1:0]    rd_stall, wr_stall, rsp_push;
  logic [64*NMC-1:0] rsp_data;
  logic [32*NMC-1:0] rsp_rdctl;
  logic [NMC-1:0]    rsp_stall, req_flush, flush_cmplt;

  vec_inc_engine #(.NUM_MC(NMC), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clock_i(clock), .reset_i(reset),
    .aeg_write_i(aeg_write), .aeg_read_i(aeg_read),
    .aeg_index_i(aeg_index), .aeg_data_i(aeg_data), .aeg_count_o(aeg_count),
    .instruction_valid_i(instruction_valid), .instruction_caep_i(caep),
    .return_data_o(return_data), .return_data_valid_o(rdv),
    .exception_o(exception), .idle_o(idle), .stall_o(stall),
    .mc_req_ld_o(req_ld), .mc_req_st_o(req_st), .mc_req_size_o(req_size),
    .mc_req_vadr_o(req_vadr), .mc_req_wrd_rdctl_o(req_wrd),
    .mc_rd_rq_stall_i(rd_stall), .mc_wr_rq_stall_i(wr_stall),
    .mc_rsp_push_i(rsp_push), .mc_rsp_data_i(rsp_data), .mc_rsp_rdctl_i(rsp_rdctl),
    .mc_rsp_stall_o(rsp_stall), .mc_req_flush_o(req_flush),
    .mc_rsp_flush_cmplt_i(flush_cmplt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] base;
    logic [31:0] count;
    logic [63:0] inc;
    logic [63:0] data0;
    int          mode;    // 0 plain, 1 ch0 load stall, 2 reverse order + store stall
    string       name;
  } vec_t;
  typedef struct { logic [31:0] idx; logic [63:0] data; } pend_t;
  typedef struct { logic [47:0] addr; logic [63:0] data; } exp_t;
  typedef struct { logic [17:0] idx; logic [63:0] wdata; logic [63:0] exp; } aeg_vec_t;

  pend_t       pend [NMC][$];
  exp_t        sbq  [NMC][$];
  logic [63:0] mem  [logic [47:0]];
  int          occ  [NMC];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] d);
    aeg_write = 1'b1; aeg_index = idx; aeg_data = d;
    @(negedge clock);
    aeg_write = 1'b0;
  endtask

  task automatic aeg_rd(input logic [17:0] idx, input logic [63:0] exp, input string name);
    aeg_read = 1'b1; aeg_index = idx;
    @(negedge clock);
    aeg_read = 1'b0;
    chk({name, " valid"}, 64'(rdv), 64'd1);
    chk(name, return_data, exp);
  endtask

  task automatic dispatch(input logic [4:0] c);
    instruction_valid = 1'b1; caep = c;
    #1 chk("stall with dispatch", 64'(stall), 64'd1);
    @(negedge clock);
    instruction_valid = 1'b0; caep = 5'd0;
  endtask

  function automatic vec_t mk(input logic [47:0] b, input logic [31:0] n, input logic [63:0] inc,
                              input logic [63:0] d0, input int m, input string nm);
    vec_t v;
    v.base = b; v.count = n; v.inc = inc; v.data0 = d0; v.mode = m; v.name = nm;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          idle_it, f_it, n_ld, n_st;
    bit          saw_rs, saw_flush;
    int          last_ld [NMC];
    pend_t       p;
    exp_t        e;
    logic [31:0] idx;
    logic [47:0] a;
    aeg_wr(18'd0, 64'(v.base));
    aeg_wr(18'd1, 64'(v.count));
    aeg_wr(18'd2, v.inc);
    mem.delete();
    for (int i = 0; i < int'(v.count); i++) mem[v.base + (48'(i) << 3)] = v.data0 + 64'(i);
    for (int c = 0; c < NMC; c++) begin
      pend[c].delete(); sbq[c].delete(); occ[c] = 0; last_ld[c] = 0;
    end
    idle_it = -1; f_it = -1; n_ld = 0; n_st = 0; saw_rs = 0; saw_flush = 0;
    dispatch(5'd0);
    for (int it = 0; it < 2000 && idle_it < 0; it++) begin
      rsp_push = '0; flush_cmplt = '0; rd_stall = '0; wr_stall = '0; aeg_write = 1'b0;
      if (v.mode == 1 && it >= 3 && it < 23) rd_stall[0] = 1'b1;
      if (v.mode == 2 && it < 30) wr_stall = '1;
      if (v.mode == 1 && it == 5) begin aeg_write = 1'b1; aeg_index = 18'd0; aeg_data = 64'hDEAD; end
`ifdef WR_FLUSH_EN
      if (f_it >= 0 && it == f_it + 1)  flush_cmplt[0] = 1'b1;
      if (f_it >= 0 && it == f_it + 11) flush_cmplt[1] = 1'b1;
`endif
      #1;
      if (idle) begin
        idle_it = it;
        chk({v.name, " no req when idle"}, 64'({req_ld, req_st}), 64'd0);
      end else begin
        if (req_flush != '0) begin
          saw_flush = 1;
          if (f_it < 0) f_it = it;
        end
        if (rd_stall[0]) chk({v.name, " ld ch0 while stalled"}, 64'(req_ld[0]), 64'd0);
        for (int c = 0; c < NMC; c++) begin
          chk({v.name, " rsp_stall"}, 64'(rsp_stall[c]), 64'(occ[c] >= FD - 2));
          if (rsp_stall[c]) saw_rs = 1;
          if (!rsp_stall[c] && pend[c].size() > 0) begin
            if (v.mode == 2) begin
              if (pend[c].size() >= 2 || it - last_ld[c] >= 5) begin
                p = pend[c].pop_back();
                rsp_push[c] = 1'b1;
              end
            end else begin
              p = pend[c].pop_front();
              rsp_push[c] = 1'b1;
            end
            if (rsp_push[c]) begin
              rsp_data[c*64 +: 64]  = p.data;
              rsp_rdctl[c*32 +: 32] = p.idx;
              occ[c]++;
              e.addr = v.base + (48'(p.idx) << 3);
              e.data = mem[e.addr] + v.inc;
              sbq[c].push_back(e);
            end
          end
          if (req_ld[c] && req_st[c]) chk({v.name, " ld and st together"}, 64'd1, 64'd0);
          if (req_st[c]) begin
            n_st++; occ[c]--;
            if (sbq[c].size() == 0) chk({v.name, " unexpected store"}, 64'd1, 64'd0);
            else begin
              e = sbq[c].pop_front();
              chk({v.name, " st vadr"}, 64'(req_vadr[c*48 +: 48]), 64'(e.addr));
              chk({v.name, " st data"}, req_wrd[c*64 +: 64], e.data);
            end
            mem[req_vadr[c*48 +: 48]] = req_wrd[c*64 +: 64];
          end else if (req_ld[c]) begin
            n_ld++;
            idx = req_wrd[c*64 +: 32];
            a = v.base + (48'(idx) << 3);
            chk({v.name, " ld channel"}, 64'(idx % NMC), 64'(c));
            chk({v.name, " ld vadr"}, 64'(req_vadr[c*48 +: 48]), 64'(a));
            p.idx = idx;
            p.data = mem.exists(a) ? mem[a] : 64'd0;
            pend[c].push_back(p);
            last_ld[c] = it;
          end
        end
      end
      @(negedge clock);
    end
    rsp_push = '0; rd_stall = '0; wr_stall = '0; flush_cmplt = '0; aeg_write = 1'b0;
    if (idle_it < 0) chk({v.name, " timeout waiting for idle"}, 64'd0, 64'd1);
`ifdef WR_FLUSH_EN
    chk({v.name, " flush pulse seen"}, 64'(saw_flush), 64'd1);
    if (f_it >= 0) chk({v.name, " idle after last cmplt"}, 64'(idle_it), 64'(f_it + 12));
`else
    chk({v.name, " flush tied low"}, 64'(saw_flush), 64'd0);
    if (v.count == 0) chk({v.name, " idle latency"}, 64'(idle_it), 64'd1);
`endif
    chk({v.name, " load count"}, 64'(n_ld), 64'(v.count));
    chk({v.name, " store count"}, 64'(n_st), 64'(v.count));
    for (int i = 0; i < int'(v.count); i++) begin
      a = v.base + (48'(i) << 3);
      chk({v.name, " final mem"}, mem[a], v.data0 + 64'(i) + v.inc);
    end
    if (v.mode == 2) chk({v.name, " rsp_stall reached"}, 64'(saw_rs), 64'd1);
    for (int c = 0; c < NMC; c++)
      chk({v.name, " queues drained"}, 64'(pend[c].size() + sbq[c].size()), 64'd0);
    aeg_rd(18'd3, 64'(v.count), {v.name, " DONE"});
    aeg_rd(18'd0, 64'(v.base), {v.name, " BASE kept"});
  endtask

  vec_t     vt [5];
  aeg_vec_t at [6];

  initial begin
    vt[0] = mk(48'h1000, 32'd4, 64'd1, 64'd5, 0, "basic");
    vt[1] = mk(48'h1000, 32'd0, 64'd1, 64'd0, 0, "count0");
    vt[2] = mk(48'h2000, 32'd10, 64'd3, 64'h100, 1, "rdstall");
    vt[3] = mk(48'h3000, 32'd8, 64'h100, 64'h40, 2, "reverse");
    vt[4] = mk(48'hFFFF_FFFF_FFF0, 32'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "wrap");
    at[0] = '{18'd0, 64'hFFFF_1234_5678_9ABC, 64'h0000_1234_5678_9ABC};
    at[1] = '{18'd1, 64'hAAAA_BBBB_0000_0007, 64'h7};
    at[2] = '{18'd2, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
    at[3] = '{18'd3, 64'h55, 64'd0};
    at[4] = '{18'd5, 64'h77, 64'd0};
    at[5] = '{18'h3FFFF, 64'h99, 64'd0};

    reset = 1'b1; aeg_write = 0; aeg_read = 0; aeg_index = '0; aeg_data = '0;
    instruction_valid = 0; caep = '0; rd_stall = '0; wr_stall = '0; rsp_push = '0;
    rsp_data = '0; rsp_rdctl = '0; flush_cmplt = '0;
    @(negedge clock); @(negedge clock);
    chk("reset idle", 64'(idle), 64'd1);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset ld/st", 64'({req_ld, req_st}), 64'd0);
    chk("reset vadr", 64'(req_vadr), 64'd0);
    chk("reset wrd", req_wrd[63:0], 64'd0);
    chk("reset rsp_stall", 64'(rsp_stall), 64'd0);
    chk("reset rdv", 64'(rdv), 64'd0);
    chk("reset exception", 64'(exception), 64'd0);
    chk("reset flush", 64'(req_flush), 64'd0);
    chk("aeg_count", 64'(aeg_count), 64'd4);
    chk("req_size", 64'(req_size), 64'hF);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      aeg_wr(at[i].idx, at[i].wdata);
      aeg_rd(at[i].idx, at[i].exp, "aeg table");
    end
    chk("rdv one cycle", 64'(rdv), 64'd1);
    @(negedge clock);
    chk("rdv drops", 64'(rdv), 64'd0);

    dispatch(5'd3);
    chk("exception pulse", 64'(exception), 64'd1);
    chk("idle after bad caep", 64'(idle), 64'd1);
    @(negedge clock);
    chk("exception clears", 64'(exception), 64'd0);
    chk("still idle", 64'(idle), 64'd1);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Reset in the middle of a run; late responses must be ignored.
    aeg_wr(18'd0, 64'h1000); aeg_wr(18'd1, 64'd4); aeg_wr(18'd2, 64'd1);
    dispatch(5'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1 chk("mid-run reset idle", 64'(idle), 64'd1);
    chk("mid-run reset no ld", 64'(req_ld), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rsp_push = '1; rsp_data = '1; rsp_rdctl = '0;
      @(negedge clock);
    end
    rsp_push = '0;
    #1 chk("stale rsp dropped", 64'(rsp_stall), 64'd0);
    chk("stale no req", 64'({req_ld, req_st}), 64'd0);
    chk("stale idle", 64'(idle), 64'd1);
    @(negedge clock);
    aeg_rd(18'd3, 64'd0, "DONE after reset");
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
